msg_load_ctrl: RTL and testbench
================================

Name: msg_load_ctrl

Overview:
Sequencer that drives the message-vector builder during one 512-bit block load. On a start pulse it walks byte addresses 0..MSG_LENGTH-1, one per cycle, with the builder enable held high. It then flags address completion and waits for the builder's vector-complete flag, with a timeout. Finally it hands the finished block to the downstream hash core over a valid/ready handshake and holds the builder enabled until the core accepts.

Parameters:
MSG_LENGTH, 55, message length in bytes; legal range 1..55 (single-block padding).
TIMEOUT, 8, max cycles in WAIT_VEC before declaring error; must be ≥ 4 (builder flag latency is 3).
AW, $clog2(MSG_LENGTH), byte-address width; derived, not overridden.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to load a block; sampled only in IDLE
abort  input  1  cancel any in-progress load; highest priority after reset
vec_complete  input  1  message-vector-complete flag from builder
hash_ready  input  1  downstream hash core accepts block
enable  output  1  builder enable; high from first address until handoff accepted
msg_address  output  AW  byte address to message memory and builder
address_read_complete  output  1  all addresses issued; held until return to IDLE
vec_valid  output  1  finished block available to hash core
busy  output  1  high in any state other than IDLE and ERROR
done  output  1  one-cycle pulse when the block is accepted
error  output  1  timeout flag; sticky until reset, abort or a new start

Behaviour:
- Reset value of every output: 0. State = IDLE, address counter = 0, timeout counter = 0.
- States: IDLE, ISSUE, WAIT_VEC, HAND, ERROR.
- IDLE: start=1 -> ISSUE and error cleared. Next cycle: enable=1, msg_address=0.
- ISSUE: enable=1. msg_address increments by 1 each cycle.
  - When msg_address == MSG_LENGTH-1, go to WAIT_VEC.
  - Addresses 0..MSG_LENGTH-1 each appear for exactly one cycle, with no gaps or repeats; the counter never wraps.
  - start is ignored here.
- WAIT_VEC: address_read_complete=1, enable=1, msg_address holds MSG_LENGTH-1.
  - Timeout counter increments each cycle.
  - vec_complete=1 -> HAND, counter cleared.
  - Counter reaches TIMEOUT with no vec_complete -> ERROR.
  - If vec_complete and the timeout fall in the same cycle, vec_complete wins.
- HAND: vec_valid=1, enable=1, address_read_complete=1.
  - hash_ready=1 -> done=1 for that cycle's next edge (registered pulse, 1 cycle), then IDLE.
  - vec_valid must stay high until accepted; no timeout in HAND.
- ERROR: error=1; enable, address_read_complete and vec_valid all 0; busy=0.
  - start=1 -> ISSUE with error cleared, same as from IDLE.
- abort=1 in any state -> IDLE next cycle, with all outputs 0 except that error keeps its value if already in ERROR.
- reset overrides abort.
- Dropping enable on return to IDLE clears the builder's vector; this is intentional.
- Latency, start to done: MSG_LENGTH (ISSUE) + wait cycles + 1 (HAND, minimum) + 1.
- msg_address is registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Basic load (MSG_LENGTH=55): reset, start at cycle 10, vec_complete 3 cycles after entering WAIT_VEC, hash_ready tied high -> addresses 0..54 on cycles 11..65, address_read_complete from cycle 66, vec_valid one cycle after vec_complete, done single pulse, busy low afterwards.
2. Backpressure: hash_ready low for 5 cycles in HAND -> vec_valid and enable held 5 cycles, done only after hash_ready=1, exactly one pulse.
3. Timeout: vec_complete never asserted -> ERROR after 8 WAIT_VEC cycles, error=1, enable=0; then a new start clears error and reissues address 0.
4. Boundary: vec_complete on the 8th WAIT_VEC cycle (the timeout cycle) -> HAND, error stays 0.
5. Abort at address 20 -> IDLE next cycle, enable=0, msg_address=0; start during ISSUE is ignored and yields no second sequence.
6. Reset mid-HAND with vec_valid=1 -> all outputs 0 next cycle, no done pulse; MSG_LENGTH=1 variant issues address 0 for one cycle, then WAIT_VEC.

Source files
------------

// File: rtl/msg_load_if.sv
// Handshake/bus bundle between the block-load sequencer and its surroundings.
// The master side is the sequencer; the slave side is the builder, memory and hash core.
interface msg_load_if #(
   parameter int AW = 6
);
   logic          start;
   logic          abort;
   logic          vec_complete;
   logic          hash_ready;
   logic          enable;
   logic [AW-1:0] msg_address;
   logic          address_read_complete;
   logic          vec_valid;
   logic          busy;
   logic          done;
   logic          error;

   modport master (
      input  start, abort, vec_complete, hash_ready,
      output enable, msg_address, address_read_complete, vec_valid, busy, done, error
   );

   modport slave (
      output start, abort, vec_complete, hash_ready,
      input  enable, msg_address, address_read_complete, vec_valid, busy, done, error
   );
endinterface

// File: rtl/msg_load_ctrl.sv
// Sequences one 512-bit block load: address walk, wait for the builder's flag, then handoff.
// Start to done takes MSG_LENGTH + wait cycles + HAND cycles + 1; HAND holds until hash_ready.
module msg_load_ctrl #(
   parameter  int MSG_LENGTH = 55,
   parameter  int TIMEOUT    = 8,
   localparam int AW         = (MSG_LENGTH > 1) ? $clog2(MSG_LENGTH) : 1
) (
   input logic        clock,
   input logic        reset,
   msg_load_if.master bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_HAND  = 3'd3;
   localparam logic [2:0] S_ERROR = 3'd4;

   localparam int            TW        = $clog2(TIMEOUT);
   localparam logic [AW-1:0] LAST_ADDR = AW'(MSG_LENGTH - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          error_q, error_d;
   logic          done_q, done_d;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      tmo_d   = tmo_q;
      error_d = error_q;
      done_d  = 1'b0;
      // abort keeps error untouched so a timeout stays visible after cancelling out of ERROR
      if (bus.abort) begin
         state_d = S_IDLE;
         addr_d  = '0;
         tmo_d   = '0;
      end else begin
         case (state_q)
            S_IDLE, S_ERROR: begin
               if (bus.start) begin
                  state_d = S_ISSUE;
                  addr_d  = '0;
                  tmo_d   = '0;
                  error_d = 1'b0;
               end
            end
            S_ISSUE: begin
               if (addr_q == LAST_ADDR) begin
                  state_d = S_WAIT;
               end else begin
                  addr_d = addr_q + AW'(1);
               end
            end
            S_WAIT: begin
               // a flag arriving on the final allowed cycle still wins over the timeout
               if (bus.vec_complete) begin
                  state_d = S_HAND;
                  tmo_d   = '0;
               end else if (tmo_q == TMO_LAST) begin
                  state_d = S_ERROR;
                  tmo_d   = '0;
                  addr_d  = '0;
                  error_d = 1'b1;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end
            S_HAND: begin
               if (bus.hash_ready) begin
                  state_d = S_IDLE;
                  addr_d  = '0;
                  done_d  = 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
               addr_d  = '0;
               tmo_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         tmo_q   <= '0;
         error_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         tmo_q   <= tmo_d;
         error_q <= error_d;
         done_q  <= done_d;
      end
   end

   // Outputs decode registered state only, so nothing combinational reaches them from inputs.
   assign bus.enable                = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_HAND);
   assign bus.busy                  = bus.enable;
   assign bus.address_read_complete = (state_q == S_WAIT) || (state_q == S_HAND);
   assign bus.vec_valid             = (state_q == S_HAND);
   assign bus.msg_address           = addr_q;
   assign bus.done                  = done_q;
   assign bus.error                 = error_q;

endmodule

// File: tb/tb_msg_load_ctrl.sv
// Randomized bench for msg_load_ctrl: stimulus pushes per-load expectations, a monitor scores each load.
module tb_msg_load_ctrl;
   localparam int ML  = 55;
   localparam int TMO = 8;
   localparam int AW  = $clog2(ML);
   localparam int O_DONE  = 0;
   localparam int O_ERR   = 1;
   localparam int O_ABORT = 2;

   typedef struct {
      int start_cyc;
      int n_addr;
      int n_wait;
      int n_hand;
      int outcome;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   skip_mon = 1'b1;
   exp_t sbq[$];

   msg_load_if #(.AW(AW)) bus0 ();
   msg_load_if #(.AW(1))  bus1 ();

   msg_load_ctrl #(.MSG_LENGTH(ML), .TIMEOUT(TMO)) u_dut (
      .clock(clock), .reset(reset), .bus(bus0));
   msg_load_ctrl #(.MSG_LENGTH(1), .TIMEOUT(TMO)) u_dut1 (
      .clock(clock), .reset(reset), .bus(bus1));

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected shape of one load, derived from the load rules rather than from any state encoding.
   function automatic exp_t model(input int k, input int r, input int ph, input int j, input int a);
      exp_t e;
      e.start_cyc = 0;
      e.n_addr    = ML;
      e.n_wait    = 0;
      e.n_hand    = 0;
      e.outcome   = O_DONE;
      if (ph == 1) begin
         e.n_addr  = a + 1;
         e.outcome = O_ABORT;
      end else if (ph == 2) begin
         e.n_wait  = j;
         e.outcome = O_ABORT;
      end else if (k > TMO) begin
         e.n_wait  = TMO;
         e.outcome = O_ERR;
      end else begin
         e.n_wait = k;
         if (ph == 3) begin
            e.n_hand  = j;
            e.outcome = O_ABORT;
         end else begin
            e.n_hand = r + 1;
         end
      end
      return e;
   endfunction

   // Monitor: rebuilds each load from the outputs and scores it against the queue head.
   bit busy_prev = 1'b0;
   int m_first, m_na, m_nw, m_nh, m_bad, m_out;
   exp_t m_e;
   always @(negedge clock) begin
      if (skip_mon) begin
         busy_prev = 1'b0;
      end else begin
         chk("enable_eq_busy", int'(bus0.enable), int'(bus0.busy));
         if (bus0.busy) chk("error_while_busy", int'(bus0.error), 0);
         if (!(busy_prev && !bus0.busy)) chk("done_stray", int'(bus0.done), 0);
         if (!bus0.busy) begin
            chk("idle_arc", int'(bus0.address_read_complete), 0);
            chk("idle_vec_valid", int'(bus0.vec_valid), 0);
            if (!bus0.error) chk("idle_addr", int'(bus0.msg_address), 0);
         end
         if (bus0.busy && !busy_prev) begin
            m_first = cyc; m_na = 0; m_nw = 0; m_nh = 0; m_bad = 0;
         end
         if (bus0.enable && !bus0.address_read_complete) begin
            if (int'(bus0.msg_address) != m_na) m_bad++;
            m_na++;
         end
         if (bus0.address_read_complete && !bus0.vec_valid && bus0.enable) begin
            if (int'(bus0.msg_address) != ML - 1) m_bad++;
            m_nw++;
         end
         if (bus0.vec_valid) m_nh++;
         if (busy_prev && !bus0.busy) begin
            m_out = bus0.done ? O_DONE : (bus0.error ? O_ERR : O_ABORT);
            chk("sb_has_entry", int'(sbq.size() > 0), 1);
            if (sbq.size() > 0) begin
               m_e = sbq.pop_front();
               chk("first_addr_latency", m_first, m_e.start_cyc + 1);
               chk("addr_count", m_na, m_e.n_addr);
               chk("addr_sequence_bad", m_bad, 0);
               chk("wait_cycles", m_nw, m_e.n_wait);
               chk("hand_cycles", m_nh, m_e.n_hand);
               chk("outcome", m_out, m_e.outcome);
            end
         end
         busy_prev = bus0.busy;
      end
   end

   task automatic clr_inputs();
      bus0.start = 1'b0; bus0.abort = 1'b0; bus0.vec_complete = 1'b0; bus0.hash_ready = 1'b0;
   endtask

   // k: WAIT cycle carrying vec_complete (>TMO = never); r: HAND cycles with hash_ready low;
   // ph: abort phase 0 none/1 ISSUE/2 WAIT/3 HAND; j: cycle within phase; a: abort address.
   task automatic run_txn(input int k, input int r, input int ph, input int j, input int a,
                          input bit start_in_issue, output int outc);
      exp_t e;
      int wc = 0;
      int hc = 0;
      int n = 0;
      e = model(k, r, ph, j, a);
      outc = e.outcome;
      @(negedge clock);
      bus0.start = 1'b1;
      e.start_cyc = cyc;
      sbq.push_back(e);
      @(negedge clock);
      while (n < 400) begin
         clr_inputs();
         if (!bus0.busy) break;
         if (bus0.enable && !bus0.address_read_complete) begin
            if (ph == 1 && int'(bus0.msg_address) == a) bus0.abort = 1'b1;
            if (start_in_issue && int'(bus0.msg_address) == 5) bus0.start = 1'b1;
         end else if (bus0.address_read_complete && !bus0.vec_valid) begin
            wc++;
            if (ph == 2 && wc == j) bus0.abort = 1'b1;
            if (wc == k) bus0.vec_complete = 1'b1;
         end else if (bus0.vec_valid) begin
            hc++;
            if (ph == 3 && hc == j) bus0.abort = 1'b1;
            bus0.hash_ready = (hc > r);
         end
         @(negedge clock);
         n++;
      end
      if (n >= 400) chk("txn_cycle_budget", n, 0);
   endtask

   task automatic after_error(input bit do_abort);
      chk("error_set", int'(bus0.error), 1);
      chk("error_enable_low", int'(bus0.enable), 0);
      if (do_abort) begin
         bus0.abort = 1'b1;
         @(negedge clock);
         bus0.abort = 1'b0;
         chk("error_kept_after_abort", int'(bus0.error), 1);
      end
   endtask

   initial begin
      int outc, k, r, ph, j, a, n;
      bus1.start = 1'b0; bus1.abort = 1'b0; bus1.vec_complete = 1'b0; bus1.hash_ready = 1'b0;
      clr_inputs();
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("rst_enable", int'(bus0.enable), 0);
      chk("rst_addr", int'(bus0.msg_address), 0);
      chk("rst_arc", int'(bus0.address_read_complete), 0);
      chk("rst_vec_valid", int'(bus0.vec_valid), 0);
      chk("rst_busy", int'(bus0.busy), 0);
      chk("rst_done", int'(bus0.done), 0);
      chk("rst_error", int'(bus0.error), 0);
      skip_mon = 1'b0;
      while (cyc < 9) @(negedge clock);

      run_txn(3, 0, 0, 0, 0, 1'b0, outc);          // basic load
      run_txn(2, 5, 0, 0, 0, 1'b0, outc);          // backpressure
      run_txn(TMO + 5, 0, 0, 0, 0, 1'b0, outc);    // timeout
      after_error(1'b0);
      run_txn(TMO, 1, 0, 0, 0, 1'b0, outc);        // flag on the timeout cycle
      run_txn(3, 0, 1, 0, 20, 1'b1, outc);         // abort at address 20, stray start
      run_txn(4, 0, 0, 0, 0, 1'b1, outc);

      for (int t = 0; t < 30; t++) begin
         k  = $urandom_range(1, TMO + 2);
         r  = $urandom_range(0, 4);
         ph = $urandom_range(0, 4);
         ph = (ph < 2) ? 0 : ph - 1;
         if (ph == 3 && k > TMO) k = $urandom_range(1, TMO);
         a = $urandom_range(0, ML - 1);
         j = 1;
         if (ph == 2) j = $urandom_range(1, (k < TMO) ? k : TMO);
         if (ph == 3) j = $urandom_range(1, r + 1);
         run_txn(k, r, ph, j, a, 1'($urandom_range(0, 1)), outc);
         if (outc == O_ERR) after_error(1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) @(negedge clock);
      end

      // Reset while a block waits in HAND: no done, everything cleared.
      skip_mon = 1'b1;
      bus0.start = 1'b1;
      @(negedge clock);
      bus0.start = 1'b0;
      n = 0;
      while (!bus0.vec_valid && n < 200) begin
         bus0.vec_complete = bus0.address_read_complete;
         @(negedge clock);
         n++;
      end
      bus0.vec_complete = 1'b0;
      chk("reached_hand", int'(bus0.vec_valid), 1);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("midrst_enable", int'(bus0.enable), 0);
      chk("midrst_vec_valid", int'(bus0.vec_valid), 0);
      chk("midrst_arc", int'(bus0.address_read_complete), 0);
      chk("midrst_busy", int'(bus0.busy), 0);
      chk("midrst_done", int'(bus0.done), 0);
      chk("midrst_addr", int'(bus0.msg_address), 0);
      @(negedge clock);
      chk("midrst_no_done_after", int'(bus0.done), 0);

      // Single-byte message on the second instance.
      bus1.start = 1'b1;
      @(negedge clock);
      bus1.start = 1'b0;
      chk("ml1_enable", int'(bus1.enable), 1);
      chk("ml1_addr", int'(bus1.msg_address), 0);
      chk("ml1_issue_arc", int'(bus1.address_read_complete), 0);
      @(negedge clock);
      chk("ml1_wait_arc", int'(bus1.address_read_complete), 1);
      chk("ml1_wait_vv", int'(bus1.vec_valid), 0);
      bus1.vec_complete = 1'b1;
      @(negedge clock);
      bus1.vec_complete = 1'b0;
      chk("ml1_hand_vv", int'(bus1.vec_valid), 1);
      bus1.hash_ready = 1'b1;
      @(negedge clock);
      bus1.hash_ready = 1'b0;
      chk("ml1_done", int'(bus1.done), 1);
      chk("ml1_busy_after", int'(bus1.busy), 0);
      @(negedge clock);
      chk("ml1_done_pulse", int'(bus1.done), 0);

      skip_mon = 1'b0;
      repeat (3) @(negedge clock);
      chk("sb_drained", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
